mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit for the P7 pipeline, sitting in EX beside the ALU.
- Executes MULT, MULTU, DIV and DIVU into the HI/LO register pair.
- Executes MTHI and MTLO as single-cycle writes.
- Produces a busy flag for the hazard unit, which stalls MFHI/MFLO and any further MDU instruction while busy or start is high.

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit_arith.sv | 69 ++++++
 rtl/mult_div_unit.sv | 98 +++++++++
 tb/tb_mult_div_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and small op-classification helpers.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // Ops 0..3 go through the multi-cycle path.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational arithmetic core of the MDU: signed/unsigned 32x32 multiply
// and signed/unsigned divide producing {hi, lo}, plus a divide-by-zero flag.
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_sgn;
    logic        [31:0] dvd;
    logic        [31:0] dvs;
    logic        [31:0] dvs_safe;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quo;
    logic        [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both DIV and DIVU. For DIV it works on
    // magnitudes; 0x80000000 has magnitude 0x80000000 as an unsigned value,
    // so the 0x80000000 / -1 case falls out as quotient 0x80000000, rem 0.
    assign div_sgn  = (op == MDU_DIV);
    assign dvd      = (div_sgn && a[31]) ? (~a + 32'd1) : a;
    assign dvs      = (div_sgn && b[31]) ? (~b + 32'd1) : b;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign q_mag    = dvd / dvs_safe;
    assign r_mag    = dvd % dvs_safe;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign quo = (div_sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem = (div_sgn && a[31])           ? (~r_mag + 32'd1) : r_mag;

    // Select the result pair for the requested op.
    always_comb begin
        hi       = 32'd0;
        lo       = 32'd0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                hi       = rem;
                lo       = quo;
                div_zero = (b == 32'd0);
            end
            default: begin
                hi       = 32'd0;
                lo       = 32'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair. The result is
// computed at the start edge and held in a pending register; HI/LO are only
// updated once the fixed busy period expires, so timing matches a real
// iterative unit while the arithmetic itself stays combinational.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;

    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    logic             div_zero;

    mdu_arith u_arith (
        .op       (op),
        .a        (A),
        .b        (B),
        .hi       (arith_hi),
        .lo       (arith_lo),
        .div_zero (div_zero)
    );

    // Control FSM, busy counter, pending result and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_arith_op(op)) begin
                            pend_hi <= arith_hi;
                            pend_lo <= arith_lo;
                            pend_wr <= ~div_zero;
                            cnt     <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end else if (op == MDU_MTHI) begin
                            HI <= A;
                        end else if (op == MDU_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                ST_RUN: begin
                    // Starts arriving here are hazard violations and are dropped.
                    if (cnt == CNT_ONE) begin
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal results
// plus randomized operations checked every cycle against a behavioural model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    bit allow_busy_start = 1'b0;

    // Reference arithmetic: returns {write_enable, hi, lo}.
    function automatic logic [64:0] ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              sa;
        int              sb;
        logic [31:0]     q;
        logic [31:0]     r;
        q = 32'd0;
        r = 32'd0;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return {1'b1, p};
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                return {1'b1, pu};
            end
            3'd2: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0, 32'h8000_0000};
                sa = a;
                sb = b;
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {1'b1, r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                q = a / b;
                r = a % b;
                return {1'b1, r, q};
            end
            default: return {1'b0, 64'd0};
        endcase
    endfunction

    // Behavioural model state.
    logic        m_busy;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_has;
    int          m_rem;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_rem  <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_has  <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                if (m_has) begin
                    m_hi <= m_phi;
                    m_lo <= m_plo;
                end
            end
        end else if (start) begin
            if (op <= 3'd3) begin
                {m_has, m_phi, m_plo} <= ref_calc(op, A, B);
                m_rem  <= (op >= 3'd2) ? 10 : 5;
                m_busy <= 1'b1;
            end else if (op == 3'd4) begin
                m_hi <= A;
            end else if (op == 3'd5) begin
                m_lo <= A;
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check65(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check32("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            check32("cyc_HI", HI, m_hi);
            check32("cyc_LO", LO, m_lo);
        end
    end

    // Hazard-unit contract: start must not be asserted while busy.
    always @(posedge clk) begin
        if (cmp_en && !reset && start && busy && !allow_busy_start) begin
            checks++;
            errors++;
            $display("FAIL hazard_start_while_busy: start=1 busy=1 required start=0 at %0t", $time);
        end
    end

    // Drive one cycle of inputs; returns just after the following negedge.
    task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
        start = s;
        op    = o;
        A     = a;
        B     = b;
        reset = r;
        @(negedge clk);
        #1;
    endtask

    // Start an arithmetic op, scramble operands while busy, check latency and result.
    task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_n);
        int n;
        n = 0;
        cyc(1'b1, o, a, b, 1'b0);
        while (busy && n < 40) begin
            n++;
            cyc(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
        end
        check32({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
        check32({name, "_HI"}, HI, exp_hi);
        check32({name, "_LO"}, LO, exp_lo);
    endtask

    initial begin
        int n;
        int k;
        int gap;
        int sel;
        logic [31:0] ra;
        logic [31:0] rb;

        // Pin the reference model with hand-computed results.
        check65("model_mult", ref_calc(3'd0, 32'hFFFF_FFFE, 32'd3), {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        check65("model_multu", ref_calc(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b1, 32'hFFFF_FFFE, 32'h0000_0001});
        check65("model_div", ref_calc(3'd2, 32'hFFFF_FFF9, 32'd2), {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check65("model_div_ovf", ref_calc(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), {1'b1, 32'd0, 32'h8000_0000});
        check65("model_divu_zero", ref_calc(3'd3, 32'd5, 32'd0), {1'b0, 64'd0});

        cyc(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cmp_en = 1'b1;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_HI", HI, 32'd0);
        check32("reset_LO", LO, 32'd0);

        run_arith("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run_arith("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        run_arith("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_arith("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        run_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

        // MTHI then MTLO back to back: single-cycle writes, never busy.
        cyc(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        check32("mthi_HI", HI, 32'h1234_5678);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        cyc(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
        check32("mtlo_LO", LO, 32'h9ABC_DEF0);
        check32("mtlo_HI", HI, 32'h1234_5678);
        check32("mtlo_busy", {31'd0, busy}, 32'd0);
        run_arith("divu_zero", 3'd3, 32'd5, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10);

        // Reserved op code: no effect.
        cyc(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check32("rsvd_busy", {31'd0, busy}, 32'd0);
        check32("rsvd_HI", HI, 32'h1234_5678);
        check32("rsvd_LO", LO, 32'h9ABC_DEF0);

        // Operands toggled while busy and a second start pulsed mid-run.
        cyc(1'b1, 3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        allow_busy_start = 1'b1;
        n = 0;
        k = 0;
        while (busy && n < 40) begin
            n++;
            k++;
            cyc((k == 2), 3'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end
        allow_busy_start = 1'b0;
        check32("toggle_busy_cycles", 32'(n), 32'd5);
        check32("toggle_HI", HI, 32'd1);
        check32("toggle_LO", LO, 32'd0);

        // Reset during the 4th busy cycle of a DIV abandons it.
        run_arith("multu_again", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        cyc(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check32("pre_reset_busy", {31'd0, busy}, 32'd1);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_HI", HI, 32'd0);
        check32("abort_LO", LO, 32'd0);
        repeat (12) cyc(1'b0, 3'd0, $urandom, $urandom, 1'b0);
        check32("late_HI", HI, 32'd0);
        check32("late_LO", LO, 32'd0);

        // Randomized traffic, including back-to-back starts and corner operands.
        repeat (150) begin
            gap = $urandom_range(0, 2);
            repeat (gap) cyc(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 17));
            else if (sel == 3) rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            cyc(1'b1, 3'($urandom_range(0, 7)), ra, rb, 1'b0);
            n = 0;
            while (busy && n < 40) begin
                n++;
                cyc(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
            end
            if (n >= 40) check32("busy_timeout", 32'(n), 32'd10);
        end

        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
